// File: rtl/rs_issue_queue.sv
// Out-of-order reservation station: two-wide dispatch, tag-broadcast wakeup on WB_NUM buses,
// oldest-ready single issue chosen through a pairwise age matrix.
module rs_issue_queue #(
  parameter int unsigned ENT_NUM  = 8,
  parameter int unsigned ENT_SEL  = $clog2(ENT_NUM),
  parameter int unsigned DATA_LEN = 32,
  parameter int unsigned ADDR_LEN = 32,
  parameter int unsigned RRF_SEL  = 6,
  parameter int unsigned OP_W     = 4,
  parameter int unsigned WB_NUM   = 5
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic [1:0]                   dp_req_num_i,
  input  logic [2*ADDR_LEN-1:0]        dp_pc_i,
  input  logic [2*DATA_LEN-1:0]        dp_op_1_i,
  input  logic [2*DATA_LEN-1:0]        dp_op_2_i,
  input  logic [1:0]                   dp_valid_1_i,
  input  logic [1:0]                   dp_valid_2_i,
  input  logic [2*DATA_LEN-1:0]        dp_imm_i,
  input  logic [2*RRF_SEL-1:0]         dp_rrf_tag_i,
  input  logic [1:0]                   dp_dst_i,
  input  logic [2*OP_W-1:0]            dp_alu_op_i,
  input  logic                         stall_dp_i,
  input  logic                         kill_i,
  input  logic [WB_NUM*DATA_LEN-1:0]   exe_result_i,
  input  logic [WB_NUM*RRF_SEL-1:0]    exe_result_dst_i,
  input  logic [WB_NUM-1:0]            exe_result_valid_i,
  output logic                         dp_allocatable_o,
  output logic [ENT_SEL:0]             free_count_o,
  output logic                         issue_valid_o,
  input  logic                         issue_ready_i,
  output logic [DATA_LEN-1:0]          issue_op_1_o,
  output logic [DATA_LEN-1:0]          issue_op_2_o,
  output logic [ADDR_LEN-1:0]          issue_pc_o,
  output logic [DATA_LEN-1:0]          issue_imm_o,
  output logic [RRF_SEL-1:0]           issue_rrf_tag_o,
  output logic                         issue_dst_val_o,
  output logic [OP_W-1:0]              issue_alu_op_o,
  output logic [ENT_NUM-1:0]           busy_vector_o
);

  localparam int unsigned CntW = ENT_SEL + 1;

  logic [ENT_NUM-1:0]  busy_q, busy_d, v1_q, v1_d, v2_q, v2_d, dst_q, dst_d;
  logic [ADDR_LEN-1:0] pc_q   [ENT_NUM];
  logic [ADDR_LEN-1:0] pc_d   [ENT_NUM];
  logic [DATA_LEN-1:0] op1_q  [ENT_NUM];
  logic [DATA_LEN-1:0] op1_d  [ENT_NUM];
  logic [DATA_LEN-1:0] op2_q  [ENT_NUM];
  logic [DATA_LEN-1:0] op2_d  [ENT_NUM];
  logic [DATA_LEN-1:0] imm_q  [ENT_NUM];
  logic [DATA_LEN-1:0] imm_d  [ENT_NUM];
  logic [RRF_SEL-1:0]  tag_q  [ENT_NUM];
  logic [RRF_SEL-1:0]  tag_d  [ENT_NUM];
  logic [OP_W-1:0]     alu_q  [ENT_NUM];
  logic [OP_W-1:0]     alu_d  [ENT_NUM];
  logic [ENT_NUM-1:0]  age_q  [ENT_NUM];
  logic [ENT_NUM-1:0]  age_d  [ENT_NUM];

  logic [CntW-1:0]     busy_cnt;
  logic [1:0]          eff_req;
  logic [1:0]          we;
  logic [ENT_SEL-1:0]  alloc_idx [2];
  logic [1:0]          alloc_found;
  logic [ENT_NUM-1:0]  ready, older, sel_oh;
  logic [ENT_SEL-1:0]  sel_idx;
  logic                sel_found, issue_fire;

  // Returns {valid, data}; lowest-index matching bus wins.
  function automatic logic [DATA_LEN:0] wake(input logic [DATA_LEN-1:0] op, input logic vld);
    logic [DATA_LEN:0] res;
    logic              hit;
    res = {vld, op};
    hit = 1'b0;
    if (!vld) begin
      for (int w = 0; w < int'(WB_NUM); w++) begin
        if (!hit && exe_result_valid_i[w] &&
            exe_result_dst_i[w*RRF_SEL +: RRF_SEL] == op[RRF_SEL-1:0]) begin
          res = {1'b1, exe_result_i[w*DATA_LEN +: DATA_LEN]};
          hit = 1'b1;
        end
      end
    end
    return res;
  endfunction

  always_comb begin
    busy_cnt = '0;
    for (int i = 0; i < int'(ENT_NUM); i++) busy_cnt = busy_cnt + CntW'(busy_q[i]);
  end

  assign free_count_o     = CntW'(ENT_NUM) - busy_cnt;
  assign busy_vector_o    = busy_q;
  assign eff_req          = (dp_req_num_i == 2'd3) ? 2'd2 : dp_req_num_i;
  assign dp_allocatable_o = free_count_o >= CntW'(eff_req);
  assign we[0] = dp_allocatable_o & ~stall_dp_i & ~kill_i & (eff_req != 2'd0);
  assign we[1] = dp_allocatable_o & ~stall_dp_i & ~kill_i & (eff_req == 2'd2);

  always_comb begin
    alloc_idx[0] = '0;
    alloc_idx[1] = '0;
    alloc_found  = '0;
    for (int i = 0; i < int'(ENT_NUM); i++) begin
      if (!busy_q[i]) begin
        if (!alloc_found[0]) begin
          alloc_idx[0]   = ENT_SEL'(i);
          alloc_found[0] = 1'b1;
        end else if (!alloc_found[1]) begin
          alloc_idx[1]   = ENT_SEL'(i);
          alloc_found[1] = 1'b1;
        end
      end
    end
  end

  // An entry is selectable when no other ready entry is older than it.
  always_comb begin
    ready     = busy_q & v1_q & v2_q;
    older     = '0;
    sel_oh    = '0;
    sel_idx   = '0;
    sel_found = 1'b0;
    for (int i = 0; i < int'(ENT_NUM); i++) begin
      for (int j = 0; j < int'(ENT_NUM); j++) older[i] = older[i] | (ready[j] & age_q[j][i]);
    end
    for (int i = 0; i < int'(ENT_NUM); i++) begin
      if (!sel_found && ready[i] && !older[i]) begin
        sel_oh[i] = 1'b1;
        sel_idx   = ENT_SEL'(i);
        sel_found = 1'b1;
      end
    end
  end

  assign issue_valid_o = sel_found & ~kill_i;
  assign issue_fire    = issue_valid_o & issue_ready_i;

  always_comb begin
    issue_op_1_o    = '0;
    issue_op_2_o    = '0;
    issue_pc_o      = '0;
    issue_imm_o     = '0;
    issue_rrf_tag_o = '0;
    issue_dst_val_o = 1'b0;
    issue_alu_op_o  = '0;
    if (issue_valid_o) begin
      issue_op_1_o    = op1_q[sel_idx];
      issue_op_2_o    = op2_q[sel_idx];
      issue_pc_o      = pc_q[sel_idx];
      issue_imm_o     = imm_q[sel_idx];
      issue_rrf_tag_o = tag_q[sel_idx];
      issue_dst_val_o = dst_q[sel_idx];
      issue_alu_op_o  = alu_q[sel_idx];
    end
  end

  always_comb begin
    busy_d = busy_q;
    v1_d   = v1_q;
    v2_d   = v2_q;
    dst_d  = dst_q;
    pc_d   = pc_q;
    op1_d  = op1_q;
    op2_d  = op2_q;
    imm_d  = imm_q;
    tag_d  = tag_q;
    alu_d  = alu_q;
    age_d  = age_q;
    for (int i = 0; i < int'(ENT_NUM); i++) begin
      if (busy_q[i]) begin
        {v1_d[i], op1_d[i]} = wake(op1_q[i], v1_q[i]);
        {v2_d[i], op2_d[i]} = wake(op2_q[i], v2_q[i]);
      end
    end
    if (issue_fire) busy_d[sel_idx] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      if (we[k]) begin
        busy_d[alloc_idx[k]] = 1'b1;
        pc_d[alloc_idx[k]]   = dp_pc_i[k*ADDR_LEN +: ADDR_LEN];
        imm_d[alloc_idx[k]]  = dp_imm_i[k*DATA_LEN +: DATA_LEN];
        tag_d[alloc_idx[k]]  = dp_rrf_tag_i[k*RRF_SEL +: RRF_SEL];
        dst_d[alloc_idx[k]]  = dp_dst_i[k];
        alu_d[alloc_idx[k]]  = dp_alu_op_i[k*OP_W +: OP_W];
        {v1_d[alloc_idx[k]], op1_d[alloc_idx[k]]} =
            wake(dp_op_1_i[k*DATA_LEN +: DATA_LEN], dp_valid_1_i[k]);
        {v2_d[alloc_idx[k]], op2_d[alloc_idx[k]]} =
            wake(dp_op_2_i[k*DATA_LEN +: DATA_LEN], dp_valid_2_i[k]);
        for (int j = 0; j < int'(ENT_NUM); j++) begin
          age_d[j][alloc_idx[k]] = busy_q[j] & ~(issue_fire & sel_oh[j]);
        end
        age_d[alloc_idx[k]] = '0;
        // Slot 1 written this cycle is older than slot 2.
        if (k == 1) age_d[alloc_idx[0]][alloc_idx[1]] = 1'b1;
      end
    end
    if (kill_i) begin
      busy_d = '0;
      for (int i = 0; i < int'(ENT_NUM); i++) age_d[i] = '0;
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      busy_q <= '0;
      v1_q   <= '0;
      v2_q   <= '0;
      dst_q  <= '0;
      for (int i = 0; i < int'(ENT_NUM); i++) begin
        pc_q[i]  <= '0;
        op1_q[i] <= '0;
        op2_q[i] <= '0;
        imm_q[i] <= '0;
        tag_q[i] <= '0;
        alu_q[i] <= '0;
        age_q[i] <= '0;
      end
    end else begin
      busy_q <= busy_d;
      v1_q   <= v1_d;
      v2_q   <= v2_d;
      dst_q  <= dst_d;
      pc_q   <= pc_d;
      op1_q  <= op1_d;
      op2_q  <= op2_d;
      imm_q  <= imm_d;
      tag_q  <= tag_d;
      alu_q  <= alu_d;
      age_q  <= age_d;
    end
  end

endmodule

// File: tb/tb_rs_issue_queue.sv
// Directed bench for rs_issue_queue: dispatch, wakeup, age-ordered issue, full queue, kill, reset.
module tb_rs_issue_queue;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [1:0]    dp_req_num;
  logic [63:0]   dp_pc, dp_op_1, dp_op_2, dp_imm;
  logic [1:0]    dp_valid_1, dp_valid_2, dp_dst;
  logic [11:0]   dp_rrf_tag;
  logic [7:0]    dp_alu_op;
  logic          stall_dp, kill;
  logic [159:0]  exe_result;
  logic [29:0]   exe_result_dst;
  logic [4:0]    exe_result_valid;
  logic          dp_allocatable;
  logic [3:0]    free_count;
  logic          issue_valid, issue_ready;
  logic [31:0]   issue_op_1, issue_op_2, issue_pc, issue_imm;
  logic [5:0]    issue_rrf_tag;
  logic          issue_dst_val;
  logic [3:0]    issue_alu_op;
  logic [7:0]    busy_vector;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  rs_issue_queue dut (
    .clk_i(clk), .reset_i(reset_n), .dp_req_num_i(dp_req_num), .dp_pc_i(dp_pc),
    .dp_op_1_i(dp_op_1), .dp_op_2_i(dp_op_2), .dp_valid_1_i(dp_valid_1),
    .dp_valid_2_i(dp_valid_2), .dp_imm_i(dp_imm), .dp_rrf_tag_i(dp_rrf_tag), .dp_dst_i(dp_dst),
    .dp_alu_op_i(dp_alu_op), .stall_dp_i(stall_dp), .kill_i(kill), .exe_result_i(exe_result),
    .exe_result_dst_i(exe_result_dst), .exe_result_valid_i(exe_result_valid),
    .dp_allocatable_o(dp_allocatable), .free_count_o(free_count), .issue_valid_o(issue_valid),
    .issue_ready_i(issue_ready), .issue_op_1_o(issue_op_1), .issue_op_2_o(issue_op_2),
    .issue_pc_o(issue_pc), .issue_imm_o(issue_imm), .issue_rrf_tag_o(issue_rrf_tag),
    .issue_dst_val_o(issue_dst_val), .issue_alu_op_o(issue_alu_op), .busy_vector_o(busy_vector)
  );

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    dp_req_num = '0; dp_pc = '0; dp_op_1 = '0; dp_op_2 = '0; dp_imm = '0;
    dp_valid_1 = '0; dp_valid_2 = '0; dp_dst = '0; dp_rrf_tag = '0; dp_alu_op = '0;
    stall_dp = 1'b0; kill = 1'b0;
    exe_result = '0; exe_result_dst = '0; exe_result_valid = '0;
  endtask

  // imm = pc + 4, dst = 1, alu_op = low nibble of tag.
  task automatic slot(input int k, input logic [31:0] pc, input logic [31:0] o1, input logic v1,
                      input logic [31:0] o2, input logic v2, input logic [5:0] tag);
    dp_pc[k*32 +: 32] = pc;
    dp_op_1[k*32 +: 32] = o1;
    dp_valid_1[k] = v1;
    dp_op_2[k*32 +: 32] = o2;
    dp_valid_2[k] = v2;
    dp_imm[k*32 +: 32] = pc + 32'd4;
    dp_rrf_tag[k*6 +: 6] = tag;
    dp_dst[k] = 1'b1;
    dp_alu_op[k*4 +: 4] = tag[3:0];
  endtask

  task automatic bus(input int w, input logic [5:0] t, input logic [31:0] d);
    exe_result_valid[w] = 1'b1;
    exe_result_dst[w*6 +: 6] = t;
    exe_result[w*32 +: 32] = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    issue_ready = 1'b0;
    reset_n = 1'b0;
    dp_req_num = 2'd2;
    #3;
    chk("rst_issue_valid", issue_valid, 0);
    chk("rst_payload", {issue_op_1, issue_pc}, 0);
    chk("rst_busy", busy_vector, 0);
    chk("rst_free", free_count, 8);
    chk("rst_alloc", dp_allocatable, 1);
    tick();
    reset_n = 1'b1;

    // Two valid instructions, issued in order.
    idle();
    issue_ready = 1'b1;
    dp_req_num = 2'd2;
    slot(0, 32'h100, 32'h11, 1, 32'h22, 1, 6'd5);
    slot(1, 32'h200, 32'h33, 1, 32'h44, 1, 6'd6);
    #1 chk("d2_alloc", dp_allocatable, 1);
    tick(); idle(); #1;
    chk("d2_busy", busy_vector, 8'h03);
    chk("d2_free", free_count, 6);
    chk("d2_tag5", issue_rrf_tag, 5);
    chk("d2_pc", issue_pc, 32'h100);
    chk("d2_ops", {issue_op_1, issue_op_2}, {32'h11, 32'h22});
    chk("d2_imm_alu_dst", {issue_imm, issue_alu_op, 3'b0, issue_dst_val}, {32'h104, 4'd5, 4'd1});
    tick(); #1;
    chk("d2_busy2", busy_vector, 8'h02);
    chk("d2_tag6", issue_rrf_tag, 6);
    chk("d2_pc6", issue_pc, 32'h200);
    tick(); #1;
    chk("d2_free8", free_count, 8);
    chk("d2_idle_valid", issue_valid, 0);
    chk("d2_idle_payload", {issue_op_1, issue_rrf_tag}, 0);

    // Wakeup on bus 2 two cycles after dispatch.
    dp_req_num = 2'd1;
    slot(0, 32'h300, 32'd9, 0, 32'h55, 1, 6'd7);
    tick(); idle(); #1;
    chk("wk_busy", busy_vector, 8'h01);
    chk("wk_wait", issue_valid, 0);
    tick();
    bus(2, 6'd9, 32'h1234);
    bus(1, 6'd8, 32'hdead);
    #1 chk("wk_bus_cycle", issue_valid, 0);
    tick(); idle(); #1;
    chk("wk_ready", issue_valid, 1);
    chk("wk_op1", issue_op_1, 32'h1234);
    chk("wk_op2_tag", {issue_op_2, issue_rrf_tag}, {32'h55, 6'd7});
    tick(); #1;
    chk("wk_done", busy_vector, 0);

    // Fill all eight entries with never-woken operands.
    issue_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      idle();
      dp_req_num = 2'd2;
      slot(0, 32'h400 + c, 32'd60, 0, 32'h1, 1, 6'(2 * c));
      slot(1, 32'h500 + c, 32'd60, 0, 32'h1, 1, 6'(2 * c + 1));
      #1;
      if (c == 3) begin
        chk("fill_free2", free_count, 2);
        chk("fill_alloc2", dp_allocatable, 1);
      end
      tick();
    end
    #1;
    chk("full_busy", busy_vector, 8'hff);
    chk("full_free", free_count, 0);
    chk("full_alloc_req2", dp_allocatable, 0);
    dp_req_num = 2'd1;
    #1 chk("full_alloc_req1", dp_allocatable, 0);
    dp_req_num = 2'd3;
    #1 chk("full_alloc_req3", dp_allocatable, 0);
    dp_req_num = 2'd0;
    #1 chk("full_alloc_req0", dp_allocatable, 1);
    dp_req_num = 2'd2;
    slot(0, 32'h600, 32'h1, 1, 32'h1, 1, 6'd50);
    tick(); #1;
    chk("full_nochange_busy", busy_vector, 8'hff);
    chk("full_nochange_valid", issue_valid, 0);
    idle();
    kill = 1'b1;
    tick(); idle(); #1;
    chk("full_kill", {busy_vector, free_count}, {8'h00, 4'd8});

    // Older entry at a higher index wins when both wake together.
    dp_req_num = 2'd1;
    slot(0, 32'h700, 32'h1, 1, 32'h2, 1, 6'd1);
    tick(); idle();
    issue_ready = 1'b1;
    dp_req_num = 2'd1;
    slot(0, 32'h710, 32'd20, 0, 32'h2, 1, 6'd10);
    #1 chk("age_x_presented", issue_rrf_tag, 1);
    tick(); idle();
    issue_ready = 1'b0;
    dp_req_num = 2'd1;
    slot(0, 32'h720, 32'd21, 0, 32'h3, 1, 6'd11);
    #1 chk("age_a_entry1", busy_vector, 8'h02);
    tick(); idle();
    bus(0, 6'd20, 32'haaaa);
    bus(1, 6'd21, 32'hbbbb);
    #1 chk("age_both_busy", {busy_vector, 7'b0, issue_valid}, {8'h03, 8'h00});
    tick(); idle();
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("age_hold_a", {issue_valid, issue_rrf_tag, issue_op_1, issue_pc},
          {1'b1, 6'd10, 32'haaaa, 32'h710});
      tick();
    end
    issue_ready = 1'b1;
    #1 chk("age_accept_a", issue_rrf_tag, 10);
    tick(); #1;
    chk("age_then_b", {issue_valid, issue_rrf_tag, issue_op_1}, {1'b1, 6'd11, 32'hbbbb});
    tick(); #1;
    chk("age_drained", busy_vector, 0);

    // Dispatch-time wakeup: bus 0 beats bus 3.
    issue_ready = 1'b0;
    dp_req_num = 2'd1;
    slot(0, 32'h800, 32'd40, 0, 32'h77, 1, 6'd12);
    bus(0, 6'd40, 32'hd0d0);
    bus(3, 6'd40, 32'hd3d3);
    tick(); idle(); #1;
    chk("dpwk_ready", issue_valid, 1);
    chk("dpwk_op1", issue_op_1, 32'hd0d0);
    issue_ready = 1'b1;
    tick(); #1;
    chk("dpwk_done", busy_vector, 0);

    // Kill with five busy entries and a concurrent dispatch.
    issue_ready = 1'b0;
    dp_req_num = 2'd2;
    slot(0, 32'h900, 32'h1, 1, 32'h1, 1, 6'd20);
    slot(1, 32'h904, 32'd61, 0, 32'h1, 1, 6'd21);
    tick(); idle();
    dp_req_num = 2'd2;
    slot(0, 32'h908, 32'd61, 0, 32'h1, 1, 6'd22);
    slot(1, 32'h90c, 32'd61, 0, 32'h1, 1, 6'd23);
    tick(); idle();
    dp_req_num = 2'd1;
    slot(0, 32'h910, 32'd61, 0, 32'h1, 1, 6'd24);
    tick(); idle(); #1;
    chk("kill_pre_busy", busy_vector, 8'h1f);
    chk("kill_pre_valid", {issue_valid, issue_rrf_tag}, {1'b1, 6'd20});
    kill = 1'b1;
    issue_ready = 1'b1;
    dp_req_num = 2'd2;
    slot(0, 32'ha00, 32'h1, 1, 32'h1, 1, 6'd30);
    slot(1, 32'ha04, 32'h1, 1, 32'h1, 1, 6'd31);
    #1 chk("kill_valid", {issue_valid, issue_pc}, 0);
    tick(); idle(); #1;
    chk("kill_busy", busy_vector, 0);
    chk("kill_free", free_count, 8);
    tick(); #1;
    chk("kill_stays_empty", busy_vector, 0);

    // Asynchronous reset in mid-operation.
    issue_ready = 1'b0;
    dp_req_num = 2'd2;
    slot(0, 32'hb00, 32'h1, 1, 32'h1, 1, 6'd32);
    slot(1, 32'hb04, 32'd62, 0, 32'h1, 1, 6'd34);
    tick(); idle(); #1;
    chk("mr_busy", busy_vector, 8'h03);
    #2 reset_n = 1'b0;
    #1;
    chk("mr_cleared", {busy_vector, free_count, 3'b0, issue_valid}, {8'h00, 4'd8, 4'd0});
    tick();
    reset_n = 1'b1;
    dp_req_num = 2'd1;
    slot(0, 32'hc00, 32'h5, 1, 32'h6, 1, 6'd33);
    tick(); idle(); #1;
    chk("mr_realloc", {busy_vector, issue_rrf_tag, issue_op_1}, {8'h01, 6'd33, 32'h5});
    issue_ready = 1'b1;
    tick(); #1;
    chk("mr_done", busy_vector, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
